substractor: RTL and testbench
==============================

SUBSTRACTOR -- requirements
Module: substractor

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range is 2 to 32.
REQ-002 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 Port a, input, WIDTH bits, minuend, unsigned or two's complement.
REQ-005 Port b, input, WIDTH bits, subtrahend.
REQ-006 Port in_valid, input, 1 bit, qualifies a and b in the current cycle.
REQ-007 Port subs_out, output, WIDTH bits, registered difference.
REQ-008 Port carry_out, output, 1 bit, registered carry of a + ~b + 1; 1 means no borrow (a >= b unsigned).
REQ-009 Port out_valid, output, 1 bit, high for one cycle when subs_out and carry_out hold a new result.
REQ-010 Port overflow, output, 1 bit, registered signed-overflow flag; exists only when SUBS_OVERFLOW_EN is defined (REQ-024).

Function
REQ-011 The difference is computed as a + (~b) + 1, modulo 2^WIDTH; there is no borrow-in.
REQ-012 carry_out is the carry out of the MSB of that sum; it is always generated, and users may ignore it.
REQ-013 Latency is 1 cycle: operands sampled with in_valid=1 at edge N appear on subs_out, carry_out and out_valid=1 after edge N.
REQ-014 When in_valid=0 at an edge, subs_out and carry_out hold their previous values and out_valid goes to 0.
REQ-015 Equal operands give subs_out=0 and carry_out=1.
REQ-016 b=0 gives subs_out=a and carry_out=1, including when a=0.
REQ-017 a < b (unsigned) wraps: for example, 4-bit 2-9 gives subs_out=4'b1001 and carry_out=0.
REQ-018 Back-to-back in_valid pulses give back-to-back results with no bubble; there is no backpressure.
REQ-019 No X-propagation from a or b occurs while in_valid=0.

Reset
REQ-020 While rst_n=0: subs_out=0, carry_out=0, out_valid=0 and overflow=0, taking effect immediately without waiting for clk.
REQ-021 Reset mid-operation discards any sampled operands; the first out_valid after release requires a fresh in_valid.
REQ-022 Reset deassertion is synchronised externally; the block adds no synchroniser.

Configuration
REQ-023 Macro SUBS_OVERFLOW_EN selects whether signed-overflow detection is compiled in.
REQ-024 With SUBS_OVERFLOW_EN defined:
- the overflow port exists;
- it registers (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
- it updates under the same rule as subs_out.
REQ-025 Without SUBS_OVERFLOW_EN, the overflow port and its logic are absent, and all other behaviour is unchanged.

Structure
REQ-026 Shared package subs_pkg holds SUBS_DEFAULT_WIDTH=4 and a result struct type (diff, carry, overflow).
REQ-027 The datapath is a ripple chain of WIDTH instances of one sub-module, subs_full_adder.
- subs_full_adder inputs: x, y, cin.
- subs_full_adder outputs: s, cout.
- It is instantiated with y=~b[i] and cin[0]=1.
REQ-028 The output register stage is in the top module only; subs_full_adder is purely combinational.

Verification
REQ-029 Assert rst_n=0 asynchronously between clock edges -> all outputs go to 0 immediately, before the next edge.
REQ-030 WIDTH=4, a=1, b=1, in_valid=1 -> next cycle subs_out=0, carry_out=1, out_valid=1.
REQ-031 WIDTH=4, a=2, b=9 -> subs_out=4'b1001, carry_out=0; with SUBS_OVERFLOW_EN, overflow=1 (2-(-7)=9 is not representable).
REQ-032 WIDTH=4, a=13, b=8 -> subs_out=4'b0101, carry_out=1; overflow=0.
REQ-033 in_valid=0 for 3 cycles after a result -> subs_out and carry_out hold, out_valid=0.
REQ-034 Exhaustive 4-bit sweep of all 256 (a,b) pairs, back-to-back -> every result matches (a-b) mod 16 and carry=(a>=b), with 1-cycle latency.

Source files
------------

// File: rtl/subs_pkg.sv
// Shared constants and result type for the substractor block.
package subs_pkg;

  localparam int unsigned SUBS_DEFAULT_WIDTH = 4;
  localparam int unsigned SUBS_MAX_WIDTH     = 32;

  typedef struct packed {
    logic [SUBS_MAX_WIDTH-1:0] diff;
    logic                      carry;
    logic                      overflow;
  } subs_result_t;

endpackage

// File: rtl/subs_full_adder.sv
// One-bit combinational full adder; one link of the subtractor ripple chain.
module subs_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  always_comb begin
    p    = x ^ y;
    s    = p ^ cin;
    cout = (x & y) | (cin & p);
  end

endmodule

// File: rtl/substractor.sv
// Registered WIDTH-bit subtractor computing a + ~b + 1 with 1-cycle latency.
// Signed-overflow output is compiled in only when SUBS_OVERFLOW_EN is defined.
module substractor
  import subs_pkg::*;
#(
  parameter int unsigned WIDTH = SUBS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] subs_out,
  output logic             carry_out,
  output logic             out_valid
`ifdef SUBS_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff;

  // Two's complement subtraction: invert b and inject the +1 as carry-in.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    subs_full_adder u_fa (
      .x    (a[i]),
      .y    (~b[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      subs_out  <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        subs_out  <= diff;
        carry_out <= carry[WIDTH];
      end
    end
  end

`ifdef SUBS_OVERFLOW_EN
  logic ovf;

  // Overflow only possible when operand signs differ and the result sign flips from a.
  assign ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_substractor.sv
// Scoreboard bench for substractor (WIDTH=4): directed vectors, full sweep, hold and reset.
module tb_substractor;
  import subs_pkg::*;

  localparam int unsigned W = 4;

  typedef struct {
    subs_result_t res;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] subs_out;
  logic         carry_out;
  logic         out_valid;
  logic         ovf_o;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_carry = 1'b0;

  substractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .subs_out  (subs_out),
    .carry_out (carry_out),
    .out_valid (out_valid)
`ifdef SUBS_OVERFLOW_EN
    ,
    .overflow  (ovf_o)
`endif
  );

`ifndef SUBS_OVERFLOW_EN
  assign ovf_o = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Hand-computed directed table: a, b, diff, carry, signed overflow.
  int unsigned va[9]   = '{1, 2, 13, 0, 5, 0, 8, 7, 15};
  int unsigned vb[9]   = '{1, 9, 8, 0, 0, 15, 1, 15, 15};
  int unsigned vd[9]   = '{0, 9, 5, 0, 5, 1, 7, 8, 0};
  int unsigned vc[9]   = '{1, 0, 1, 1, 1, 0, 1, 0, 1};
  int unsigned vo[9]   = '{0, 1, 0, 0, 0, 0, 1, 1, 0};

  task automatic issue(input int unsigned ia, input int unsigned ib, input int unsigned d,
                       input int unsigned c, input int unsigned o);
    exp_t e;
    @(posedge clk);
    #1;
    a        = ia[W-1:0];
    b        = ib[W-1:0];
    in_valid = 1'b1;
    e.res          = '0;
    e.res.diff     = SUBS_MAX_WIDTH'(d);
    e.res.carry    = c[0];
    e.res.overflow = o[0];
    e.cyc          = cyc + 1;
    sb_q.push_back(e);
    last_diff  = d[W-1:0];
    last_carry = c[0];
  endtask

  function automatic int sval(input int unsigned v);
    return (v >= 8) ? int'(v) - 16 : int'(v);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("subs_out", int'(subs_out), int'(e.res.diff[W-1:0]));
        check("carry_out", int'(carry_out), int'(e.res.carry));
`ifdef SUBS_OVERFLOW_EN
        check("overflow", int'(ovf_o), int'(e.res.overflow));
`endif
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_subs_out", int'(subs_out), 0);
    check("reset_carry_out", int'(carry_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_overflow", int'(ovf_o), 0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) issue(va[i], vb[i], vd[i], vc[i], vo[i]);

    // Exhaustive back-to-back sweep using an independent arithmetic model.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int sd;
        sd = sval(ia) - sval(ib);
        issue(ia, ib, (ia - ib + 16) % 16, (ia >= ib) ? 1 : 0, (sd > 7 || sd < -8) ? 1 : 0);
      end
    end

    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 4'hx;
    b = 4'hx;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 0);
      check("hold_subs_out", int'(subs_out), int'(last_diff));
      check("hold_carry_out", int'(carry_out), int'(last_carry));
    end
    check("queue_drained", sb_q.size(), 0);

    // Asynchronous reset between edges, with an operand sampled while in reset.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_subs_out", int'(subs_out), 0);
    check("async_rst_carry_out", int'(carry_out), 0);
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_overflow", int'(ovf_o), 0);
    a = 4'd3;
    b = 4'd1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_valid", int'(out_valid), 0);
    end

    issue(9, 3, 6, 1, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("final_queue_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
